cbm2_bus_sequencer: RTL
=======================

Name: cbm2_bus_sequencer

Overview:
- Sequential successor to the combinational CBM-II bus decoder.
- Arbitrates between two bus masters (CPU and video fetch) and decodes the 24-bit {segment, address} into RAM, write-protected ROM image, I/O page or open bus.
- Runs a request/acknowledge handshake with the SDRAM controller, with timeout, and with the I/O chips, with programmable wait states.
- Returns latched read data per master.

Parameters:
- ADDR_W, 24: system address width; bits [ADDR_W-1:16] are the segment, and only the low 4 segment bits are decoded.
- DATA_W, 8: data bus width.
- IO_PAGES, 8: number of one-hot I/O page selects for $D800-$DFFF in segment 15; page = addr[10:8] mod IO_PAGES.
- IO_WAIT, 2: cycles io_sel is held before io_rdata is sampled (1..15).
- RAM_TIMEOUT, 31: cycles without ram_ack before the access is aborted (1..255).
- ROM_WP, 1: 1 = writes to ROM-image ranges are acknowledged but not issued.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous reset, active-high
- model  in  1  0=Professional (P2), 1=Business (B2)
- ramSize  in  2  0=128k, 1=256k, 2=1M, 3=16M
- ipcRamEn  in  1  enable segment-15 RAM at $0800-$0FFF
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write
- cpu_addr  in  ADDR_W  CPU {segment, address}
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_di  out  DATA_W  latched CPU read data
- vid_req  in  1  video fetch request (read only), held until vid_ack
- vid_addr  in  ADDR_W  video fetch address
- vid_ack  out  1  one-cycle completion pulse
- vid_di  out  DATA_W  latched video read data
- ram_req  out  1  SDRAM request, level
- ram_we  out  1  SDRAM write
- ram_addr  out  ADDR_W  SDRAM address
- ram_wdata  out  DATA_W  SDRAM write data
- ram_ack  in  1  SDRAM done; read data valid this cycle
- ram_rdata  in  DATA_W  SDRAM read data
- io_sel  out  IO_PAGES  one-hot I/O page select
- io_we  out  1  I/O write strobe (valid with io_sel)
- io_wdata  out  DATA_W  I/O write data
- io_rdata  in  DATA_W  muxed I/O read data

Behaviour:
- Reset values: every output is 0, except cpu_di and vid_di, which reset to all-ones. State IDLE; round-robin pointer = video. Reset mid-access takes effect in the same clk_sys edge: ram_req and io_sel are 0 on the next cycle and no ack is issued.
- FSM states: IDLE, RAM, IO, ACK.
- IDLE arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the master not granted last (round-robin).
  - On grant: latch master, address, we and wdata; decode; move to RAM, IO or ACK.
- Decode, segment 15:
  - $0000-$07FF: RAM.
  - $0800-$0FFF: RAM if ipcRamEn, else open.
  - $1000-$CFFF: ROM image in RAM. $C000-$CFFF is open when model=1.
  - $D000-$D7FF: RAM.
  - $D800-$DFFF: IO.
  - $E000-$FFFF: ROM image.
- Decode, segments 0-14, RAM only if in range:
  - ramSize 0: P2 seg<=1; B2 seg 1..2.
  - ramSize 1: P2 seg<=3; B2 seg 1..4.
  - ramSize 2/3: all segments.
  - Anything else is open.
- Video requests decode identically but never write.
- Open bus: go directly to ACK with read data all-ones; no ram_req, no io_sel.
- ROM-image write with ROM_WP=1: go directly to ACK; no ram_req, read latch unchanged.
- RAM state:
  - ram_req=1 with ram_addr/ram_we/ram_wdata stable from the first RAM cycle; a counter starts at 0.
  - When ram_ack is seen: latch ram_rdata (reads) into the master's di in that same edge, drop ram_req, go to ACK.
  - If the counter reaches RAM_TIMEOUT with no ack: drop ram_req, latch all-ones, go to ACK.
  - ram_ack seen while in IDLE/IO/ACK is ignored.
- IO state:
  - io_sel one-hot for IO_WAIT cycles; io_we=latched we; io_wdata=latched wdata.
  - On the last wait cycle, latch io_rdata (reads), then go to ACK with io_sel cleared.
- ACK state: pulse the granted master's ack for exactly one cycle, update the round-robin pointer, return to IDLE.
- Throughput and latency:
  - A new grant is possible in the cycle after ACK.
  - Minimum latency from req to ack: open = 2 cycles, RAM = 3 + SDRAM latency, IO = 2 + IO_WAIT.
- Master rules: a master's req dropped before ack is a protocol error. The access still completes and the ack is still pulsed. Latched data of the non-granted master never changes.

Test Plan:
- CPU read seg 15 $E123, ram_ack 4 cycles after ram_req → ram_addr=0F_E123, cpu_di=ram_rdata, cpu_ack 1-cycle pulse, vid_ack stays 0.
- CPU write seg 15 $F000 with ROM_WP=1 → no ram_req, cpu_ack 2 cycles after req. Then seg 15 $0810 with ipcRamEn=0 → read returns $FF, no ram_req.
- cpu_req and vid_req both held continuously → grants alternate video, CPU, video…; each master's di matches its own address data.
- CPU read $DC05 in segment 15, IO_WAIT=2 → io_sel=8'b0001_0000 for exactly 2 cycles, cpu_di=io_rdata sampled on the 2nd cycle.
- model=1, ramSize=0, read segment 3 → open bus $FF; segment 2 → ram_req. Never ack RAM → abort after 31 cycles, cpu_di=$FF, ram_req low.
- Assert reset while in RAM state → next cycle ram_req=0, state IDLE, no ack. Then cpu_di=$FF, and a subsequent request completes normally.

Source files
------------

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II bus sequencer: arbitrates CPU and video fetch, decodes {segment, address},
// and runs the SDRAM and I/O handshakes, returning latched read data per master.
module cbm2_bus_sequencer #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 8,
  parameter int IO_PAGES    = 8,
  parameter int IO_WAIT     = 2,
  parameter int RAM_TIMEOUT = 31,
  parameter int ROM_WP      = 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                model,
  input  logic [1:0]          ramSize,
  input  logic                ipcRamEn,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_di,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_di,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [IO_PAGES-1:0] io_sel,
  output logic                io_we,
  output logic [DATA_W-1:0]   io_wdata,
  input  logic [DATA_W-1:0]   io_rdata
);

  // state  | meaning
  // S_IDLE | arbitrate and decode a pending request
  // S_RAM  | ram_req held until ram_ack or timeout
  // S_IO   | io_sel held for IO_WAIT cycles
  // S_ACK  | pulse the granted master's ack
  typedef enum logic [1:0] {S_IDLE, S_RAM, S_IO, S_ACK} state_t;
  typedef enum logic [1:0] {R_RAM, R_ROM, R_IO, R_OPEN} region_t;

  state_t              state;
  logic                gnt_vid;
  logic                rr_vid;
  logic                lat_we;
  logic [7:0]          ram_cnt;
  logic [3:0]          io_cnt;

  logic                cpu_pend;
  logic                vid_pend;
  logic                pick_vid;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_wdata;
  logic [3:0]          seg;
  logic [15:0]         off;
  logic                seg_ram;
  region_t             region;
  logic [IO_PAGES-1:0] page_sel;

  // A master whose ack is showing still has its req up for that cycle; masking it
  // stops the same access from being granted twice.
  assign cpu_pend  = cpu_req && !cpu_ack;
  assign vid_pend  = vid_req && !vid_ack;
  assign pick_vid  = vid_pend && (!cpu_pend || rr_vid);
  assign sel_addr  = pick_vid ? vid_addr : cpu_addr;
  assign sel_we    = !pick_vid && cpu_we;
  assign sel_wdata = pick_vid ? '0 : cpu_wdata;
  assign seg       = sel_addr[19:16];
  assign off       = sel_addr[15:0];

  always_comb begin
    seg_ram = 1'b0;
    unique case (ramSize)
      2'd0:    seg_ram = model ? (seg >= 4'd1 && seg <= 4'd2) : (seg <= 4'd1);
      2'd1:    seg_ram = model ? (seg >= 4'd1 && seg <= 4'd4) : (seg <= 4'd3);
      default: seg_ram = 1'b1;
    endcase
  end

  always_comb begin
    region = R_OPEN;
    if (seg == 4'hF) begin
      if (off < 16'h0800)      region = R_RAM;
      else if (off < 16'h1000) region = ipcRamEn ? R_RAM : R_OPEN;
      else if (off < 16'hD000) region = (model && off >= 16'hC000) ? R_OPEN : R_ROM;
      else if (off < 16'hD800) region = R_RAM;
      else if (off < 16'hE000) region = R_IO;
      else                     region = R_ROM;
    end else if (seg_ram) begin
      region = R_RAM;
    end
  end

  always_comb begin
    page_sel = '0;
    for (int p = 0; p < IO_PAGES; p++)
      page_sel[p] = ((int'(sel_addr[10:8]) % IO_PAGES) == p);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt_vid   <= 1'b0;
      rr_vid    <= 1'b1;
      lat_we    <= 1'b0;
      ram_cnt   <= '0;
      io_cnt    <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_di    <= '1;
      vid_di    <= '1;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      io_sel    <= '0;
      io_we     <= 1'b0;
      io_wdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_pend || vid_pend) begin
            gnt_vid <= pick_vid;
            lat_we  <= sel_we;
            unique case (region)
              R_RAM, R_ROM: begin
                // Write-protected ROM image: acknowledge without touching SDRAM.
                if (region == R_ROM && sel_we && ROM_WP != 0) begin
                  state <= S_ACK;
                end else begin
                  ram_req   <= 1'b1;
                  ram_we    <= sel_we;
                  ram_addr  <= sel_addr;
                  ram_wdata <= sel_wdata;
                  ram_cnt   <= '0;
                  state     <= S_RAM;
                end
              end
              R_IO: begin
                io_sel   <= page_sel;
                io_we    <= sel_we;
                io_wdata <= sel_wdata;
                io_cnt   <= 4'(IO_WAIT - 1);
                state    <= S_IO;
              end
              default: begin
                if (!sel_we) begin
                  if (pick_vid) vid_di <= '1;
                  else          cpu_di <= '1;
                end
                state <= S_ACK;
              end
            endcase
          end
        end
        S_RAM: begin
          if (ram_ack) begin
            if (!lat_we) begin
              if (gnt_vid) vid_di <= ram_rdata;
              else         cpu_di <= ram_rdata;
            end
            ram_req <= 1'b0;
            state   <= S_ACK;
          end else if (ram_cnt == 8'(RAM_TIMEOUT - 1)) begin
            if (!lat_we) begin
              if (gnt_vid) vid_di <= '1;
              else         cpu_di <= '1;
            end
            ram_req <= 1'b0;
            state   <= S_ACK;
          end else begin
            ram_cnt <= ram_cnt + 8'd1;
          end
        end
        S_IO: begin
          if (io_cnt == 4'd0) begin
            if (!lat_we) begin
              if (gnt_vid) vid_di <= io_rdata;
              else         cpu_di <= io_rdata;
            end
            io_sel <= '0;
            io_we  <= 1'b0;
            state  <= S_ACK;
          end else begin
            io_cnt <= io_cnt - 4'd1;
          end
        end
        default: begin
          if (gnt_vid) vid_ack <= 1'b1;
          else         cpu_ack <= 1'b1;
          rr_vid <= !gnt_vid;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
